manchester_frame_encoder: RTL

Parametrised framed Manchester transmitter, successor to the team's free-running 2x-clock Manchester encoder. It accepts DATA_W-bit words over a valid/ready stream and emits a complete RF frame on one serial line: preamble, MSB-first Manchester data, then an end-of-frame code violation. It sits between the packet builder and the RF front-end. Bit rate, preamble length and bit polarity are set by parameter, and the output enable is a real port rather than internal tri-state.

---
 rtl/manchester_frame_encoder_pkg.sv | 22 ++
 rtl/manchester_frame_encoder_if.sv | 31 +++
 rtl/manchester_frame_encoder_tick_gen.sv | 34 +++
 rtl/manchester_frame_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/manchester_frame_encoder_pkg.sv
// ---------------------------------------------------------------------------
// manchester_pkg
// Shared definitions for the framed Manchester transmitter:
//   - state_e        : encoder FSM states (IDLE, PREAMBLE, DATA, STOP)
//   - POL_THOMAS     : first half-bit = b, second = ~b
//   - POL_IEEE       : first half-bit = ~b, second = b (IEEE 802.3)
//   - STOP_HALF_BITS : length of the end-of-frame code violation
// ---------------------------------------------------------------------------
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    STOP     = 2'd3
  } state_e;

  localparam int POL_THOMAS     = 0;
  localparam int POL_IEEE       = 1;
  localparam int STOP_HALF_BITS = 4;

endpackage

// File: rtl/manchester_frame_encoder_if.sv
// ---------------------------------------------------------------------------
// manchester_frame_encoder_if
// Valid/ready word stream feeding the Manchester frame encoder.
//   s_data  : word to transmit (DATA_W bits)
//   s_valid : s_data/s_last valid
//   s_last  : word is the final word of the frame
//   s_ready : encoder can take a word this cycle
// Modports: master = word producer, slave = encoder.
// ---------------------------------------------------------------------------
interface manchester_frame_encoder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/manchester_frame_encoder_tick_gen.sv
// ---------------------------------------------------------------------------
// manchester_tick_gen
// Half-bit timebase: counts 0..HALF_BIT_DIV-1 and wraps; o_half_tick is high
// in the last cycle of each half-bit (the wrap cycle).
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   i_clr       : synchronous clear, holds the count at 0
//   o_half_tick : high on the final clk of a half-bit
// ---------------------------------------------------------------------------
module manchester_tick_gen #(
  parameter int HALF_BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_half_tick
);
  localparam int CNT_W = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_half_tick = (r_cnt == CNT_LAST);
endmodule

// File: rtl/manchester_frame_encoder.sv
// ---------------------------------------------------------------------------
// manchester_frame_encoder
// Framed Manchester transmitter: preamble (1,0,1,...), MSB-first data words,
// then STOP_HALF_BITS low half-bits as an end-of-frame code violation.
// Optional build macro: MANCH_PARITY_EN adds an even-parity Manchester bit
// after bit 0 of every word.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   s_if      : slave word stream (s_data, s_valid, s_last, s_ready)
//   tx_out    : registered Manchester line level
//   tx_oe     : registered line driver enable, high for the whole frame
//   busy      : frame in progress
//   underrun  : one-cycle pulse when a frame is aborted for missing data
// ---------------------------------------------------------------------------
module manchester_frame_encoder
  import manchester_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int PREAMBLE_BITS = 16,
  parameter int HALF_BIT_DIV  = 4,
  parameter int POLARITY      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  manchester_frame_encoder_if.slave   s_if,
  output logic                        tx_out,
  output logic                        tx_oe,
  output logic                        busy,
  output logic                        underrun
);
`ifdef MANCH_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS  = DATA_W + PAR_BITS;
  localparam int IDX_W  = $clog2(DATA_W + 1);
  localparam int PRE_W  = $clog2(PREAMBLE_BITS + 1);
  localparam int STOP_W = $clog2(STOP_HALF_BITS + 1);

  localparam logic [IDX_W-1:0]  IDX_START = IDX_W'(NBITS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PREAMBLE_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_HALF_BITS - 1);
  localparam logic              POL_INV   = (POLARITY == POL_IEEE);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_PREAMBLE = PREAMBLE;
  localparam logic [1:0] S_DATA     = DATA;
  localparam logic [1:0] S_STOP     = STOP;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_last;
  logic              r_half;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [PRE_W-1:0]  r_pre_cnt;
  logic [STOP_W-1:0] r_stop_cnt;
  logic              r_tx_out;
  logic              r_tx_oe;
  logic              r_underrun;
`ifdef MANCH_PARITY_EN
  logic              r_parity;
`endif

  logic w_half_tick;
  logic w_bit_done;
  logic w_word_end;
  logic w_ready;
  logic w_bit;
  logic w_level;

  manchester_tick_gen #(
    .HALF_BIT_DIV (HALF_BIT_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state == S_IDLE),
    .o_half_tick (w_half_tick)
  );

  // A Manchester bit ends on the tick that closes its second half.
  assign w_bit_done = w_half_tick && r_half;
  assign w_word_end = (r_state == S_DATA) && w_bit_done && (r_bit_idx == '0);
  // Ready in IDLE, or for the single end-of-word cycle of a non-final word.
  assign w_ready    = (r_state == S_IDLE) || (w_word_end && !r_last);

  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      S_PREAMBLE: w_bit = ~r_pre_cnt[0];
      S_DATA: begin
        w_bit = r_shift[DATA_W-1];
`ifdef MANCH_PARITY_EN
        // Index 0 is the parity slot once all data bits have been sent.
        if (r_bit_idx == '0) w_bit = r_parity;
`endif
      end
      default: w_bit = 1'b0;
    endcase
  end

  // Second half carries the complement; POL_IEEE swaps the halves.
  assign w_level = ((r_state == S_PREAMBLE) || (r_state == S_DATA))
                 ? (w_bit ^ r_half ^ POL_INV) : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_half     <= 1'b0;
      r_bit_idx  <= '0;
      r_pre_cnt  <= '0;
      r_stop_cnt <= '0;
      r_tx_out   <= 1'b0;
      r_tx_oe    <= 1'b0;
      r_underrun <= 1'b0;
`ifdef MANCH_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_tx_out   <= w_level;
      r_tx_oe    <= (r_state != S_IDLE);
      r_underrun <= 1'b0;

      if (r_state == S_IDLE) begin
        r_half <= 1'b0;
      end else if (w_half_tick) begin
        r_half <= ~r_half;
      end

      case (r_state)
        S_IDLE: begin
          if (s_if.s_valid) begin
            r_shift   <= s_if.s_data;
            r_last    <= s_if.s_last;
`ifdef MANCH_PARITY_EN
            r_parity  <= ^s_if.s_data;
`endif
            r_pre_cnt <= '0;
            r_state   <= S_PREAMBLE;
          end
        end

        S_PREAMBLE: begin
          if (w_bit_done) begin
            if (r_pre_cnt == PRE_LAST) begin
              r_bit_idx <= IDX_START;
              r_state   <= S_DATA;
            end else begin
              r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
          end
        end

        S_DATA: begin
          if (w_bit_done) begin
            r_shift <= r_shift << 1;
            if (r_bit_idx != '0) begin
              r_bit_idx <= r_bit_idx - IDX_W'(1);
            end else if (r_last) begin
              r_stop_cnt <= '0;
              r_state    <= S_STOP;
            end else if (s_if.s_valid) begin
              // Reload overrides the shift above: next word starts with no gap.
              r_shift   <= s_if.s_data;
              r_last    <= s_if.s_last;
`ifdef MANCH_PARITY_EN
              r_parity  <= ^s_if.s_data;
`endif
              r_bit_idx <= IDX_START;
            end else begin
              r_underrun <= 1'b1;
              r_stop_cnt <= '0;
              r_state    <= S_STOP;
            end
          end
        end

        S_STOP: begin
          if (w_half_tick) begin
            if (r_stop_cnt == STOP_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + STOP_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.s_ready = w_ready;
  assign tx_out       = r_tx_out;
  assign tx_oe        = r_tx_oe;
  assign busy         = (r_state != S_IDLE);
  assign underrun     = r_underrun;
endmodule
